// File: rtl/time_pkg.sv
// time_pkg: shared time-of-day type, field limits and BCD helper functions
// used by the BCD time-of-day counter and its digit-pair sub-counter.
package time_pkg;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;
    localparam logic [7:0] HR_MAX  = 8'h23;

    // A field is acceptable when both nibbles are decimal digits and the value
    // does not exceed the field maximum. Once both nibbles are decimal, packed
    // BCD orders exactly like the decimal value, so a plain compare is enough.
    function automatic logic bcd_ok(input logic [7:0] val, input logic [7:0] max_val);
        return (val[3:0] <= 4'd9) && (val[7:4] <= 4'd9) && (val <= max_val);
    endfunction

    // Next BCD value of a two-digit field that wraps to 00 after max_val.
    function automatic logic [7:0] bcd_next(input logic [7:0] val, input logic [7:0] max_val);
        logic [7:0] nxt;
        if (val == max_val) begin
            nxt = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            nxt = {val[7:4] + 4'd1, 4'd0};
        end else begin
            nxt = {val[7:4], val[3:0] + 4'd1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one two-digit BCD field (seconds, minutes or hours).
// Loads a value, or counts up on inc and wraps after max_val, flagging
// the wrap on carry in the same cycle as the incrementing request.
module bcd_digit_cnt
    import time_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic [7:0] max_val,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = inc && (value == max_val);

    // Field register: reset, then load, then count, in that priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= bcd_next(value, max_val);
        end
    end

endmodule

// File: rtl/bcd_time_cnt.sv
// bcd_time_cnt: BCD time-of-day counter (hh:mm:ss) driven by a hundredths
// tick from an upstream prescaler, with a validated parallel load.
// Optional alarm feature is enabled by defining BCD_TIME_ALARM_EN.
module bcd_time_cnt
    import time_pkg::*;
#(
    parameter int         TICKS_PER_SEC = 100,
    parameter logic [7:0] RST_HH        = 8'h12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       set_vld,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_p,
    output logic       day_p,
    output logic       set_err
`ifdef BCD_TIME_ALARM_EN
    ,
    input  logic       alm_wr,
    input  logic [7:0] alm_hh,
    input  logic [7:0] alm_mm,
    input  logic       alm_on,
    output logic       alarm_p
`endif
);

    localparam logic [7:0] SUB_LAST = 8'(TICKS_PER_SEC - 1);

    logic [7:0] sub_cnt;
    bcd_time_t  set_time;
    logic       set_ok;
    logic       sec_strobe;
    logic       adv;
    logic       ss_carry;
    logic       mm_carry;
    logic       hh_carry;

    assign set_time   = {set_hh, set_mm, set_ss};
    assign set_ok     = set_vld && bcd_ok(set_time.hh, HR_MAX)
                                && bcd_ok(set_time.mm, MIN_MAX)
                                && bcd_ok(set_time.ss, SEC_MAX);
    assign sec_strobe = tick_in && (sub_cnt == SUB_LAST);
    // A valid load wins over a coincident second; a rejected load does not block it.
    assign adv        = sec_strobe && !set_ok;

    // Hundredths prescaler: cleared by a valid load, wraps on the second strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt <= 8'd0;
        end else if (set_ok) begin
            sub_cnt <= 8'd0;
        end else if (tick_in) begin
            sub_cnt <= (sub_cnt == SUB_LAST) ? 8'd0 : sub_cnt + 8'd1;
        end
    end

    bcd_digit_cnt #(.RST_VAL(8'h00)) u_ss (
        .clk      (clk),
        .rst      (rst),
        .inc      (adv),
        .load     (set_ok),
        .load_val (set_time.ss),
        .max_val  (SEC_MAX),
        .value    (ss),
        .carry    (ss_carry)
    );

    bcd_digit_cnt #(.RST_VAL(8'h00)) u_mm (
        .clk      (clk),
        .rst      (rst),
        .inc      (ss_carry),
        .load     (set_ok),
        .load_val (set_time.mm),
        .max_val  (MIN_MAX),
        .value    (mm),
        .carry    (mm_carry)
    );

    bcd_digit_cnt #(.RST_VAL(RST_HH)) u_hh (
        .clk      (clk),
        .rst      (rst),
        .inc      (mm_carry),
        .load     (set_ok),
        .load_val (set_time.hh),
        .max_val  (HR_MAX),
        .value    (hh),
        .carry    (hh_carry)
    );

    // Status pulses, registered so they line up with the updated time.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_p   <= 1'b0;
            day_p   <= 1'b0;
            set_err <= 1'b0;
        end else begin
            sec_p   <= adv;
            day_p   <= hh_carry;
            set_err <= set_vld && !set_ok;
        end
    end

`ifdef BCD_TIME_ALARM_EN
    logic [7:0] alm_hh_q;
    logic [7:0] alm_mm_q;
    bcd_time_t  next_time;
    logic       alm_match;

    // The alarm fires only on a minute boundary reached by counting, so the
    // next time is derived from the carries rather than from a load.
    assign next_time.ss = 8'h00;
    assign next_time.mm = bcd_next(mm, MIN_MAX);
    assign next_time.hh = mm_carry ? bcd_next(hh, HR_MAX) : hh;
    assign alm_match    = ss_carry && (next_time.hh == alm_hh_q)
                                   && (next_time.mm == alm_mm_q);

    // Alarm time storage and one-cycle alarm pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            alm_hh_q <= 8'h00;
            alm_mm_q <= 8'h00;
            alarm_p  <= 1'b0;
        end else begin
            if (alm_wr) begin
                alm_hh_q <= alm_hh;
                alm_mm_q <= alm_mm;
            end
            alarm_p <= alm_on && alm_match;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_time_cnt.sv
// tb_bcd_time_cnt: scoreboard bench for bcd_time_cnt. A seconds-of-day model
// predicts each cycle's outputs; a monitor compares them one cycle later.
// Alarm checks are included when BCD_TIME_ALARM_EN is defined.
module tb_bcd_time_cnt;

    localparam int TPS   = 100;
    localparam int RST_H = 12;

    typedef struct {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       sec_p;
        logic       day_p;
        logic       set_err;
        logic       alarm_p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       set_vld;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       sec_p;
    logic       day_p;
    logic       set_err;
`ifdef BCD_TIME_ALARM_EN
    logic       alm_wr;
    logic [7:0] alm_hh;
    logic [7:0] alm_mm;
    logic       alm_on;
    logic       alarm_p;
    int         m_alm_min;
`endif

    exp_t exp_q[$];
    int   num_checks = 0;
    int   num_pass   = 0;
    int   m_t;
    int   m_sub;

    bcd_time_cnt #(.TICKS_PER_SEC(TPS), .RST_HH(8'h12)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .set_vld (set_vld),
        .set_hh  (set_hh),
        .set_mm  (set_mm),
        .set_ss  (set_ss),
        .hh      (hh),
        .mm      (mm),
        .ss      (ss),
        .sec_p   (sec_p),
        .day_p   (day_p),
        .set_err (set_err)
`ifdef BCD_TIME_ALARM_EN
        ,
        .alm_wr  (alm_wr),
        .alm_hh  (alm_hh),
        .alm_mm  (alm_mm),
        .alm_on  (alm_on),
        .alarm_p (alarm_p)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic bit field_ok(input logic [7:0] v, input int limit);
        int hi;
        int lo;
        hi = int'(v[7:4]);
        lo = int'(v[3:0]);
        return (hi <= 9) && (lo <= 9) && (hi * 10 + lo < limit);
    endfunction

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    // Drive one cycle of inputs and push the outputs the model expects after that edge.
    task automatic applyStimulus(input logic r, input logic tk, input logic sv,
                                 input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] sx);
        exp_t e;
        @(negedge clk);
        rst = r; tick_in = tk; set_vld = sv;
        set_hh = sh; set_mm = sm; set_ss = sx;
        e.sec_p = 1'b0; e.day_p = 1'b0; e.set_err = 1'b0; e.alarm_p = 1'b0;
        if (r) begin
            m_t   = RST_H * 3600;
            m_sub = 0;
`ifdef BCD_TIME_ALARM_EN
            m_alm_min = 0;
`endif
        end else begin
            if (sv && field_ok(sh, 24) && field_ok(sm, 60) && field_ok(sx, 60)) begin
                m_t   = bcd_val(sh) * 3600 + bcd_val(sm) * 60 + bcd_val(sx);
                m_sub = 0;
            end else begin
                e.set_err = sv;
                if (tk) begin
                    m_sub = m_sub + 1;
                    if (m_sub == TPS) begin
                        m_sub   = 0;
                        m_t     = (m_t + 1) % 86400;
                        e.sec_p = 1'b1;
                        e.day_p = (m_t == 0);
`ifdef BCD_TIME_ALARM_EN
                        e.alarm_p = alm_on && (m_t == m_alm_min * 60);
`endif
                    end
                end
            end
`ifdef BCD_TIME_ALARM_EN
            if (alm_wr) m_alm_min = bcd_val(alm_hh) * 60 + bcd_val(alm_mm);
`endif
        end
        e.hh = to_bcd(m_t / 3600);
        e.mm = to_bcd((m_t / 60) % 60);
        e.ss = to_bcd(m_t % 60);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic act_alarm;
`ifdef BCD_TIME_ALARM_EN
        act_alarm = alarm_p;
`else
        act_alarm = 1'b0;
`endif
        num_checks++;
        if (hh === e.hh && mm === e.mm && ss === e.ss && sec_p === e.sec_p &&
            day_p === e.day_p && set_err === e.set_err && act_alarm === e.alarm_p) begin
            num_pass++;
        end else begin
            $display("[TB] FAIL outputs@check%0d t=%0t: got %h:%h:%h sec=%b day=%b err=%b alm=%b, expected %h:%h:%h sec=%b day=%b err=%b alm=%b",
                     num_checks, $time, hh, mm, ss, sec_p, day_p, set_err, act_alarm,
                     e.hh, e.mm, e.ss, e.sec_p, e.day_p, e.set_err, e.alarm_p);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic ticks(input int n, input bit gappy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
            if (gappy && ($urandom_range(0, 2) == 0)) idle(1);
        end
    endtask

    task automatic load(input logic tk, input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] sx);
        applyStimulus(1'b0, tk, 1'b1, sh, sm, sx);
    endtask

    // Monitor: compare one expected record per clock, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    logic [7:0] r_h;
    logic [7:0] r_m;
    logic [7:0] r_s;
    logic       r_rst;
    logic       r_tk;
    logic       r_sv;

    initial begin
        rst = 1'b1; tick_in = 1'b0; set_vld = 1'b0;
        set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
        m_t = RST_H * 3600; m_sub = 0;
`ifdef BCD_TIME_ALARM_EN
        alm_wr = 1'b0; alm_hh = 8'h00; alm_mm = 8'h00; alm_on = 1'b0; m_alm_min = 0;
`endif
        $display("[TB] start");

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'h03);
        idle(2);

        ticks(TPS, 1'b0);
        idle(3);

        load(1'b0, 8'h23, 8'h59, 8'h59);
        ticks(TPS, 1'b1);
        idle(2);

        load(1'b0, 8'h12, 8'h09, 8'h59);
        ticks(TPS, 1'b0);
        idle(2);

        ticks(TPS - 1, 1'b0);
        load(1'b1, 8'h10, 8'h6A, 8'h00);
        idle(2);

        ticks(TPS - 1, 1'b0);
        load(1'b1, 8'h05, 8'h00, 8'h00);
        ticks(TPS, 1'b1);
        idle(2);

        load(1'b0, 8'h24, 8'h00, 8'h00);
        load(1'b1, 8'h19, 8'h59, 8'h59);
        ticks(TPS, 1'b0);

        ticks(TPS / 2, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h05, 8'h05, 8'h05);
        ticks(TPS, 1'b0);

`ifdef BCD_TIME_ALARM_EN
        alm_hh = 8'h07; alm_mm = 8'h30; alm_wr = 1'b1;
        idle(1);
        alm_wr = 1'b0; alm_on = 1'b1;
        load(1'b0, 8'h07, 8'h29, 8'h59);
        ticks(TPS, 1'b0);
        idle(2);
        alm_on = 1'b0;
        load(1'b0, 8'h07, 8'h29, 8'h59);
        ticks(TPS, 1'b0);
        alm_on = 1'b1;
        load(1'b0, 8'h07, 8'h30, 8'h00);
        idle(3);
`endif

        for (int i = 0; i < 5000; i++) begin
            r_rst = ($urandom_range(0, 999) < 2);
            r_tk  = ($urandom_range(0, 3) != 0);
            r_sv  = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 2))
                0: begin
                    r_h = to_bcd($urandom_range(0, 23));
                    r_m = to_bcd($urandom_range(0, 59));
                    r_s = to_bcd($urandom_range(0, 59));
                end
                1: begin
                    r_h = ($urandom_range(0, 1) == 0) ? 8'h23 : to_bcd($urandom_range(0, 23));
                    r_m = 8'h59;
                    r_s = to_bcd($urandom_range(57, 59));
                end
                default: begin
                    r_h = 8'($urandom);
                    r_m = 8'($urandom);
                    r_s = 8'($urandom);
                end
            endcase
`ifdef BCD_TIME_ALARM_EN
            alm_wr = ($urandom_range(0, 199) == 0);
            alm_hh = r_h;
            alm_mm = ($urandom_range(0, 1) == 0) ? 8'h00 : to_bcd($urandom_range(0, 59));
            if ($urandom_range(0, 99) == 0) alm_on = ~alm_on;
`endif
            applyStimulus(r_rst, r_tk, r_sv, r_h, r_m, r_s);
        end
`ifdef BCD_TIME_ALARM_EN
        alm_wr = 1'b0;
`endif
        idle(1);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            num_checks++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule

// File: doc/bcd_time_cnt.md
BCD_TIME_CNT -- requirements
Module: bcd_time_cnt

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100: number of tick_in pulses per second (2..255).
REQ-002 SHALL have parameter RST_HH, default 8'h12: BCD hour loaded on reset.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port tick_in, input, 1: one-cycle enable from the upstream prescaler, which counts in hundredths of a second.
REQ-006 SHALL have port set_vld, input, 1: load request for set_hh/set_mm/set_ss.
REQ-007 SHALL have ports set_hh, set_mm, set_ss, input, 8 each: BCD load values.
REQ-008 SHALL have ports hh, mm, ss, output, 8 each: current BCD time, registered.
REQ-009 SHALL have port sec_p, output, 1: one-cycle pulse on every seconds increment.
REQ-010 SHALL have port day_p, output, 1: one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
REQ-011 SHALL have port set_err, output, 1: one-cycle pulse when a load is rejected.

Function
REQ-012 SHALL keep an internal prescale counter sub_cnt, 0..TICKS_PER_SEC-1, incremented on each tick_in.
REQ-013 SHALL generate an internal second strobe when tick_in=1 and sub_cnt=TICKS_PER_SEC-1; sub_cnt then wraps to 0 in the same cycle.
REQ-014 SHALL, on the second strobe, increment ss and register hh/mm/ss plus sec_p one cycle after the tick edge (latency 1).
REQ-015 SHALL wrap ss 59->00 with carry into mm, mm 59->00 with carry into hh, and hh 23->00, with day_p asserted.
REQ-016 SHALL keep every digit valid BCD: low nibble 9->0 with carry, high nibble ss/mm 0..5 and hh 0..2; hh low nibble 0..3 when the high nibble is 2.
REQ-017 SHALL, on set_vld with all fields valid BCD in range, load hh/mm/ss next cycle, clear sub_cnt and suppress sec_p/day_p that cycle.
REQ-018 SHALL, on set_vld with any field invalid (e.g. mm=8'h6A or hh=8'h24), leave the time unchanged, pulse set_err, and process a coincident tick normally.
REQ-019 SHALL give a valid set_vld priority over a coincident tick_in; that tick is discarded.
REQ-020 SHALL ignore tick_in levels held for several cycles beyond counting each high cycle as one tick.

Reset
REQ-021 SHALL, with rst=1 at a clock edge, set hh=RST_HH, mm=8'h00, ss=8'h00, sub_cnt=0, and sec_p=day_p=set_err=alarm_p=0.
REQ-022 SHALL let rst override set_vld and tick_in in the same cycle, including when asserted mid-count.

Configuration
REQ-023 SHALL use macro BCD_TIME_ALARM_EN.
REQ-024 SHALL, when BCD_TIME_ALARM_EN is defined, add the following ports:
  - alm_wr, input, 1
  - alm_hh and alm_mm, input, 8 each
  - alm_on, input, 1
  - alarm_p, output, 1
REQ-025 SHALL, with BCD_TIME_ALARM_EN defined, store alm_hh/alm_mm on alm_wr (reset value 00:00) and pulse alarm_p for one cycle when the time becomes alm_hh:alm_mm:00 by a count, only while alm_on=1.
REQ-026 SHALL not pulse alarm_p when the matching time is reached by a load.
REQ-027 SHALL, without BCD_TIME_ALARM_EN, omit those ports and the alarm registers entirely.

Structure
REQ-028 SHALL place in shared package time_pkg:
  - typedef bcd_time_t (packed hh, mm, ss)
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HR_MAX=8'h23
  - function bcd_ok()
REQ-029 SHALL use sub-module bcd_digit_cnt, instantiated once per 2-digit field, with:
  - inputs: inc, load value, max value
  - outputs: value, wrap carry

Verification
REQ-030 SHALL cover reset, then 100 tick_in pulses: ss 00->01, sec_p exactly once, the pulse one cycle after the 100th tick.
REQ-031 SHALL cover load 23:59:59, then 100 ticks: time 00:00:00, with day_p and sec_p pulsed in the same cycle.
REQ-032 SHALL cover load 12:09:59, then one second: 12:10:00 (BCD carry 09->10 in mm, 59->00 in ss).
REQ-033 SHALL cover set_vld with mm=8'h6A coincident with the 100th tick: time advances by one second, and set_err pulses once.
REQ-034 SHALL cover valid set_vld 05:00:00 coincident with the 100th tick: time 05:00:00 with sub_cnt cleared, and next sec_p only after 100 further ticks.
REQ-035 SHALL cover, with BCD_TIME_ALARM_EN: alarm 07:30, alm_on=1, load 07:29:59, one second: alarm_p one pulse; and with alm_on=0: no pulse.
